// File: rtl/cndm_pcie_msi_irq.sv
// Multi-vector MSI interrupt controller for the UltraScale+ PCIe cfg_interrupt_msi port.
// Latches and masks per-vector requests, arbitrates round-robin, handles sent/fail with retry.
module cndm_pcie_msi_irq #(
    parameter int IRQ_CNT     = 32,
    parameter int RETRY_DELAY = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_CNT-1:0] irq_req,
    input  logic [IRQ_CNT-1:0] irq_mask,
    output logic [IRQ_CNT-1:0] irq_pending,
    input  logic [3:0]         cfg_interrupt_msi_enable,
    input  logic [11:0]        cfg_interrupt_msi_mmenable,
    output logic [31:0]        cfg_interrupt_msi_int,
    input  logic               cfg_interrupt_msi_sent,
    input  logic               cfg_interrupt_msi_fail,
    output logic [7:0]         cfg_interrupt_msi_function_number,
    output logic [2:0]         cfg_interrupt_msi_attr,
    output logic               stat_sent,
    output logic               stat_fail
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, BACKOFF} state_t;

    localparam int IDX_W   = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;
    localparam int MAX_CNT = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t             state_q, state_d;
    logic [IRQ_CNT-1:0] pend_q, pend_d;
    logic [4:0]         inflight_q, inflight_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        msi_int_q, msi_int_d;
    logic               stat_sent_q, stat_sent_d;
    logic               stat_fail_q, stat_fail_d;
    logic [1:0]         rst_sync_q;

    logic [IRQ_CNT-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         mme;
    logic [4:0]         vec_mask;
    logic               rst_hold;
    logic               unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    // Reset asserts immediately but releases two clocks after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_hold = rst_sync_q[1];

    assign eligible = pend_q & ~irq_mask;
    assign mme      = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
    assign vec_mask = 5'((6'd1 << mme) - 6'd1);

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < IRQ_CNT; i++) begin
            idx = IDX_W'((int'(rr_q) + i) % IRQ_CNT);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        inflight_d  = inflight_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        stat_sent_d = 1'b0;
        stat_fail_d = 1'b0;
        msi_int_d   = (state_q == SEND) ? (32'd1 << (inflight_q & vec_mask)) : 32'd0;

        case (state_q)
            IDLE: begin
                if (cfg_interrupt_msi_enable[0] && found) begin
                    state_d    = SEND;
                    pend_d     = pend_q & ~(IRQ_CNT'(1) << grant_idx);
                    inflight_d = 5'(grant_idx);
                    rr_d       = IDX_W'((int'(grant_idx) + 1) % IRQ_CNT);
                end
            end
            SEND: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(TIMEOUT - 1);
            end
            WAIT: begin
                // fail wins over a simultaneous sent; an expired count is a fail too
                if (cfg_interrupt_msi_fail || (!cfg_interrupt_msi_sent && cnt_q == '0)) begin
                    state_d     = BACKOFF;
                    pend_d      = pend_q | (IRQ_CNT'(1) << inflight_q);
                    stat_fail_d = 1'b1;
                    cnt_d       = CNT_W'(RETRY_DELAY - 1);
                end else if (cfg_interrupt_msi_sent) begin
                    state_d     = IDLE;
                    stat_sent_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BACKOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_d | irq_req;

        if (rst_hold) begin
            state_d     = IDLE;
            pend_d      = '0;
            inflight_d  = '0;
            rr_d        = '0;
            cnt_d       = '0;
            msi_int_d   = '0;
            stat_sent_d = 1'b0;
            stat_fail_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            inflight_q  <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            msi_int_q   <= '0;
            stat_sent_q <= 1'b0;
            stat_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            inflight_q  <= inflight_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            msi_int_q   <= msi_int_d;
            stat_sent_q <= stat_sent_d;
            stat_fail_q <= stat_fail_d;
        end
    end

    assign irq_pending                       = pend_q;
    assign cfg_interrupt_msi_int             = msi_int_q;
    assign cfg_interrupt_msi_function_number = 8'd0;
    assign cfg_interrupt_msi_attr            = 3'd0;
    assign stat_sent                         = stat_sent_q;
    assign stat_fail                         = stat_fail_q;

endmodule
